// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bundle: one valid/ready pair plus destination address and data per source.
// Address and data fields for requester i are packed at [i*ADDR_SIZE +: ADDR_SIZE] and [i*XLEN +: XLEN].
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_SIZE = 5,
    parameter int XLEN      = 64
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*XLEN-1:0]      req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among several writeback sources,
// with a registered output stage and a busy scoreboard used by issue stall logic.
module regfile_wb_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ADDR_SIZE     = 5,
    parameter int XLEN          = 64,
    parameter int NUM_REGISTERS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_wb_arbiter_if.slave      req,
    input  logic                     issue_valid,
    input  logic [ADDR_SIZE-1:0]     issue_addr,
    output logic [NUM_REGISTERS-1:0] busy,
    output logic                     write_enable,
    output logic [ADDR_SIZE-1:0]     write_addr,
    output logic [XLEN-1:0]          write_data
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W-1:0]         next_ptr;
    logic [NUM_REQ-1:0]       grant;
    logic                     grant_found;
    logic                     write_pending;
    logic [NUM_REGISTERS-1:0] busy_next;
    int                       scan_idx;

    logic [ADDR_SIZE-1:0] addr_arr [NUM_REQ];
    logic [XLEN-1:0]      data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req.req_addr[i*ADDR_SIZE +: ADDR_SIZE];
        assign data_arr[i] = req.req_data[i*XLEN +: XLEN];
    end

    // Scan from the farthest offset back to rr_ptr so the closest valid requester is the last one kept.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req.req_valid[PTR_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign next_ptr      = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign req.req_ready = rst ? '0 : grant;

    // Output stage; a register-0 writeback still consumes its grant but never reaches the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            write_pending <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
        end else if (grant_found) begin
            rr_ptr        <= next_ptr;
            write_addr    <= addr_arr[grant_idx];
            write_data    <= data_arr[grant_idx];
            write_pending <= (addr_arr[grant_idx] != '0);
        end else begin
            write_pending <= 1'b0;
        end
    end

    // Gating with rst discards a write still in flight when reset arrives.
    assign write_enable = write_pending & ~rst;

    always_comb begin
        busy_next    = busy;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NUM_REGISTERS; r++) begin
            if (issue_valid && (issue_addr == ADDR_SIZE'(r))) begin
                busy_next[r] = 1'b1;
            end else if (write_pending && (write_addr == ADDR_SIZE'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter, checked every cycle against a
// behavioural model of the arbitration order, output stage and busy scoreboard.
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ       = 3;
    localparam int ADDR_SIZE     = 5;
    localparam int XLEN          = 64;
    localparam int NUM_REGISTERS = 32;

    logic                     clk;
    logic                     rst;
    logic                     issue_valid;
    logic [ADDR_SIZE-1:0]     issue_addr;
    logic [NUM_REGISTERS-1:0] busy;
    logic                     write_enable;
    logic [ADDR_SIZE-1:0]     write_addr;
    logic [XLEN-1:0]          write_data;

    logic [NUM_REQ-1:0]   drv_valid;
    logic [ADDR_SIZE-1:0] drv_addr [NUM_REQ];
    logic [XLEN-1:0]      drv_data [NUM_REQ];

    int compared   = 0;
    int mismatched = 0;

    int                       m_ptr;
    bit                       m_we;
    bit [ADDR_SIZE-1:0]       m_waddr;
    bit [XLEN-1:0]            m_wdata;
    bit [NUM_REGISTERS-1:0]   m_busy;
    bit                       refill;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_SIZE(ADDR_SIZE), .XLEN(XLEN)) bus ();

    assign bus.req_valid = drv_valid;
    assign bus.req_addr  = {drv_addr[2], drv_addr[1], drv_addr[0]};
    assign bus.req_data  = {drv_data[2], drv_data[1], drv_data[0]};

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_SIZE(ADDR_SIZE), .XLEN(XLEN), .NUM_REGISTERS(NUM_REGISTERS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .busy         (busy),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester that wins: first valid one visiting indices ptr, ptr+1, ... modulo NUM_REQ.
    function automatic int model_winner();
        if (rst) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c = (m_ptr + k) % NUM_REQ;
            if (drv_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_busy  = '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [ADDR_SIZE-1:0] a, input logic [XLEN-1:0] d);
        drv_valid[i] = 1'b1;
        drv_addr[i]  = a;
        drv_data[i]  = d;
    endtask

    // One clock: compare DUT to model mid-cycle, advance the model at the edge, then retire the winner.
    task automatic step();
        int          mw;
        logic [63:0] exp_ready;
        @(negedge clk);
        mw        = model_winner();
        exp_ready = (mw < 0) ? 64'd0 : (64'd1 << mw);
        checkOutput("req_ready", 64'(bus.req_ready), exp_ready);
        checkOutput("write_enable", 64'(write_enable), 64'(m_we && !rst));
        if (m_we && !rst) begin
            checkOutput("write_addr", 64'(write_addr), 64'(m_waddr));
            checkOutput("write_data", write_data, m_wdata);
        end
        checkOutput("busy", 64'(busy), 64'(m_busy));
        @(posedge clk);
        mw = model_winner();
        if (rst) begin
            model_reset();
        end else begin
            for (int r = 1; r < NUM_REGISTERS; r++) begin
                if (issue_valid && issue_addr == ADDR_SIZE'(r)) m_busy[r] = 1'b1;
                else if (m_we && m_waddr == ADDR_SIZE'(r))     m_busy[r] = 1'b0;
            end
            if (mw >= 0) begin
                m_ptr   = (mw + 1) % NUM_REQ;
                m_waddr = drv_addr[mw];
                m_wdata = drv_data[mw];
                m_we    = (drv_addr[mw] != 0);
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        if (rst) drv_valid = '0;
        else if (mw >= 0) begin
            if (refill) applyStimulus(mw, ADDR_SIZE'($urandom_range(1, 31)), {$urandom, $urandom});
            else drv_valid[mw] = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        drv_valid   = '0;
        issue_valid = 1'b0;
        refill      = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_addr  = '0;
        drv_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_addr[i] = '0;
            drv_data[i] = '0;
        end
        refill = 1'b0;
        model_reset();

        do_reset();
        #1;
        checkOutput("reset write_addr", 64'(write_addr), 64'd0);
        checkOutput("reset write_data", write_data, 64'd0);
        checkOutput("reset write_enable", 64'(write_enable), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);

        $display("[TB] single requester latency");
        applyStimulus(0, 5'd5, 64'hDEAD);
        #1;
        checkOutput("t1 ready cycle0", 64'(bus.req_ready), 64'b001);
        step();
        checkOutput("t1 we cycle1", 64'(write_enable), 64'd1);
        checkOutput("t1 addr cycle1", 64'(write_addr), 64'd5);
        checkOutput("t1 data cycle1", write_data, 64'hDEAD);
        step();
        checkOutput("t1 we cycle2", 64'(write_enable), 64'd0);

        $display("[TB] all requesters continuously valid");
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, ADDR_SIZE'(i + 1), {$urandom, $urandom});
        #1;
        for (int k = 0; k < 6; k++) begin
            checkOutput("t2 grant order", 64'(bus.req_ready), 64'd1 << (k % NUM_REQ));
            checkOutput("t2 write_enable", 64'(write_enable), 64'(k > 0));
            step();
        end
        checkOutput("t2 write_enable tail", 64'(write_enable), 64'd1);
        refill    = 1'b0;
        drv_valid = '0;

        $display("[TB] round-robin skips idle requester");
        do_reset();
        applyStimulus(0, 5'd3, 64'h11);
        step();
        applyStimulus(0, 5'd4, 64'h22);
        applyStimulus(2, 5'd6, 64'h33);
        #1;
        checkOutput("t3 first grant", 64'(bus.req_ready), 64'b100);
        step();
        checkOutput("t3 second grant", 64'(bus.req_ready), 64'b001);
        step();

        $display("[TB] scoreboard set and clear");
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        issue_valid = 1'b0;
        checkOutput("t4 busy7 cycle1", 64'(busy[7]), 64'd1);
        step();
        checkOutput("t4 busy7 cycle2", 64'(busy[7]), 64'd1);
        step();
        checkOutput("t4 busy7 cycle3", 64'(busy[7]), 64'd1);
        applyStimulus(1, 5'd7, {$urandom, $urandom});
        step();
        checkOutput("t4 busy7 cycle4", 64'(busy[7]), 64'd1);
        checkOutput("t4 we cycle4", 64'(write_enable), 64'd1);
        step();
        checkOutput("t4 busy7 cycle5", 64'(busy[7]), 64'd0);

        $display("[TB] issue beats clear");
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        applyStimulus(0, 5'd9, 64'h99);
        step();
        checkOutput("t5 we", 64'(write_enable), 64'd1);
        checkOutput("t5 waddr", 64'(write_addr), 64'd9);
        step();
        issue_valid = 1'b0;
        checkOutput("t5 busy9 after collision", 64'(busy[9]), 64'd1);
        step();
        checkOutput("t5 busy9 held", 64'(busy[9]), 64'd1);

        $display("[TB] register zero and reset mid-flight");
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        applyStimulus(0, 5'd0, 64'h55);
        step();
        issue_valid = 1'b0;
        checkOutput("t6 no write for r0", 64'(write_enable), 64'd0);
        checkOutput("t6 busy r0", 64'(busy), 64'd0);
        applyStimulus(0, 5'd1, 64'h66);
        applyStimulus(1, 5'd2, 64'h77);
        #1;
        checkOutput("t6 ptr advanced", 64'(bus.req_ready), 64'b010);
        drv_valid[0] = 1'b0;
        applyStimulus(1, 5'd3, 64'h88);
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        step();
        issue_valid = 1'b0;
        rst         = 1'b1;
        drv_valid   = '0;
        #1;
        checkOutput("t6 write discarded", 64'(write_enable), 64'd0);
        checkOutput("t6 busy3 before reset", 64'(busy[3]), 64'd1);
        step();
        rst = 1'b0;
        checkOutput("t6 busy cleared", 64'(busy), 64'd0);
        applyStimulus(0, 5'd1, 64'h1);
        applyStimulus(1, 5'd2, 64'h2);
        #1;
        checkOutput("t6 ptr cleared", 64'(bus.req_ready), 64'b001);
        step();
        drv_valid = '0;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = ADDR_SIZE'($urandom_range(0, 7));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!drv_valid[i] && $urandom_range(0, 1) == 1)
                    applyStimulus(i, ADDR_SIZE'($urandom_range(0, 7)), {$urandom, $urandom});
            end
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
